// File: rtl/vpu_framebuf_gen2.sv
// Pixel-addressed frame buffer: CPU register window (pointer, packed write/read,
// signed move, hardware fill) and a frame-latched scan-out port driving rgb.
module vpu_framebuf_gen2 #(
   parameter int ADDR_BITS = 16,
   parameter int BPP       = 4,
   parameter int H_VISIBLE = 256,
   parameter int V_VISIBLE = 240
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [2:0]     reg_sel,
   input  logic           reg_we,
   input  logic [7:0]     reg_wdata,
   output logic [7:0]     reg_rdata,
   output logic           busy,
   input  logic [8:0]     hpos,
   input  logic [8:0]     vpos,
   output logic [BPP-1:0] rgb
);

   localparam int PPB     = 8 / BPP;
   localparam int HI_BITS = ADDR_BITS - 8;
   localparam int DEPTH   = 2 ** ADDR_BITS;
   localparam logic [8:0] H_LIM = 9'(H_VISIBLE);
   localparam logic [8:0] V_LIM = 9'(V_VISIBLE);

   typedef enum logic {ST_IDLE, ST_RUN} fill_state_e;

   fill_state_e          state_q, state_d;
   logic [HI_BITS-1:0]   hi_q, hi_d;
   logic [7:0]           lo_q, lo_d;
   logic [ADDR_BITS-1:0] scan_q, scan_d;
   logic [7:0]           base_q, base_d;
   logic [BPP-1:0]       fill_color_q, fill_color_d;
   logic [7:0]           fill_cnt_q, fill_cnt_d;
   logic                 busy_q, busy_d;
   logic [BPP-1:0]       rgb_q, rgb_d;
   logic [ADDR_BITS-1:0] ptr;
   logic                 cpu_wr_en, fill_wr_en;
   logic [7:0]           rd_pack;

   logic [BPP-1:0]       ram_q [DEPTH];

   assign ptr   = {hi_q, lo_q};
   assign busy  = busy_q;
   assign rgb   = rgb_q;

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      scan_d       = scan_q;
      base_d       = base_q;
      fill_color_d = fill_color_q;
      fill_cnt_d   = fill_cnt_q;
      busy_d       = busy_q;
      rgb_d        = '0;
      cpu_wr_en    = 1'b0;
      fill_wr_en   = 1'b0;

      if (state_q == ST_RUN) begin
         fill_wr_en   = 1'b1;
         {hi_d, lo_d} = ptr + ADDR_BITS'(1);
         fill_cnt_d   = fill_cnt_q - 8'd1;
         if (fill_cnt_q == 8'd1) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      end

      // Only the colour register stays writable while the fill engine owns the pointer.
      if (reg_we) begin
         if (reg_sel == 3'd4) begin
            fill_color_d = reg_wdata[BPP-1:0];
         end else if (!busy_q) begin
            case (reg_sel)
               3'd0: hi_d = HI_BITS'(reg_wdata);
               3'd1: lo_d = reg_wdata;
               3'd2: begin
                  cpu_wr_en    = 1'b1;
                  {hi_d, lo_d} = ptr + ADDR_BITS'(PPB);
               end
               3'd3: begin
                  hi_d = hi_q + HI_BITS'($signed(reg_wdata[7:4]));
                  lo_d = lo_q + 8'($signed(reg_wdata[3:0]));
               end
               3'd5: begin
                  if (reg_wdata != 8'd0) begin
                     state_d    = ST_RUN;
                     busy_d     = 1'b1;
                     fill_cnt_d = reg_wdata;
                  end
               end
               3'd6: base_d = reg_wdata;
               default: ;
            endcase
         end
      end

      if (hpos < H_LIM && vpos < V_LIM) begin
         rgb_d  = ram_q[scan_q];
         scan_d = scan_q + ADDR_BITS'(1);
      end else if (vpos == V_LIM) begin
         scan_d = ADDR_BITS'({base_q, 8'h00});
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         hi_q         <= '0;
         lo_q         <= '0;
         scan_q       <= '0;
         base_q       <= '0;
         fill_color_q <= '0;
         fill_cnt_q   <= '0;
         busy_q       <= 1'b0;
         rgb_q        <= '0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         scan_q       <= scan_d;
         base_q       <= base_d;
         fill_color_q <= fill_color_d;
         fill_cnt_q   <= fill_cnt_d;
         busy_q       <= busy_d;
         rgb_q        <= rgb_d;
      end
   end

   // Pixel RAM: the first packed pixel sits in the MSBs of the CPU byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (cpu_wr_en) begin
            for (int k = 0; k < PPB; k++) begin
               ram_q[ptr + ADDR_BITS'(k)] <= reg_wdata[7-k*BPP -: BPP];
            end
         end
         if (fill_wr_en) begin
            ram_q[ptr] <= fill_color_q;
         end
      end
   end

   always_comb begin
      rd_pack = '0;
      for (int k = 0; k < PPB; k++) begin
         rd_pack[7-k*BPP -: BPP] = ram_q[ptr + ADDR_BITS'(k)];
      end
   end

   always_comb begin
      case (reg_sel)
         3'd0:    reg_rdata = 8'(hi_q);
         3'd1:    reg_rdata = lo_q;
         3'd2:    reg_rdata = rd_pack;
         3'd3:    reg_rdata = {7'b0, busy_q};
         3'd4:    reg_rdata = 8'(fill_color_q);
         3'd5:    reg_rdata = fill_cnt_q;
         3'd6:    reg_rdata = base_q;
         default: reg_rdata = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_vpu_framebuf_gen2.sv
// Bench for vpu_framebuf_gen2: register-window vector table plus hand-written
// fill, wrap, scan-out and reset sequences, all checked through a scoreboard queue.
module tb_vpu_framebuf_gen2;

   localparam int K_RD   = 0;
   localparam int K_RGB  = 1;
   localparam int K_BUSY = 2;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] reg_sel;
   logic       reg_we;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       busy;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic [3:0] rgb;

   vpu_framebuf_gen2 dut (
      .clk(clk), .reset(reset), .reg_sel(reg_sel), .reg_we(reg_we),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .busy(busy),
      .hpos(hpos), .vpos(vpos), .rgb(rgb)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      int         kind;
      logic [7:0] exp;
   } sb_t;

   typedef struct {
      string      name;
      bit         we;
      logic [2:0] wsel;
      logic [7:0] wdata;
      logic [2:0] rsel;
      logic [7:0] exp;
   } vec_t;

   sb_t  sbq[$];
   vec_t vecs[$];
   int   checks = 0;
   int   passes = 0;

   task automatic pushExp(input string name, input int kind, input logic [7:0] exp);
      sb_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sbq.push_back(e);
   endtask

   task automatic checkOutput();
      sb_t        e;
      logic [7:0] act;
      checks++;
      if (sbq.size() == 0) begin
         $display("[TB] FAIL scoreboard_empty: got no entry, required one");
         return;
      end
      e = sbq.pop_front();
      case (e.kind)
         K_RD:    act = reg_rdata;
         K_RGB:   act = {4'b0, rgb};
         default: act = {7'b0, busy};
      endcase
      if (act === e.exp) passes++;
      else $display("[TB] FAIL %s: got 0x%02h required 0x%02h", e.name, act, e.exp);
   endtask

   task automatic cpuWrite(input logic [2:0] sel, input logic [7:0] data);
      @(negedge clk);
      reg_sel   = sel;
      reg_wdata = data;
      reg_we    = 1'b1;
      @(negedge clk);
      reg_we    = 1'b0;
   endtask

   task automatic readCheck(input string name, input logic [2:0] sel, input logic [7:0] exp);
      @(negedge clk);
      reg_sel = sel;
      pushExp(name, K_RD, exp);
      #1;
      checkOutput();
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.we) cpuWrite(v.wsel, v.wdata);
      readCheck(v.name, v.rsel, v.exp);
   endtask

   task automatic scanCycle(input logic [8:0] h, input logic [8:0] v,
                            input logic [7:0] exp, input string name);
      hpos = h;
      vpos = v;
      pushExp(name, K_RGB, exp);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic addVec(input string n, input bit we, input logic [2:0] ws,
                         input logic [7:0] wd, input logic [2:0] rs, input logic [7:0] ex);
      vec_t v;
      v.name = n; v.we = we; v.wsel = ws; v.wdata = wd; v.rsel = rs; v.exp = ex;
      vecs.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, required $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b0; reg_we = 1'b0; reg_sel = 3'd0; reg_wdata = 8'h00;
      hpos = 9'd0; vpos = 9'd300;

      addVec("rst_hi",          0, 3'd0, 8'h00, 3'd0, 8'h00);
      addVec("rst_lo",          0, 3'd0, 8'h00, 3'd1, 8'h00);
      addVec("rst_busy",        0, 3'd0, 8'h00, 3'd3, 8'h00);
      addVec("rst_color",       0, 3'd0, 8'h00, 3'd4, 8'h00);
      addVec("rst_cnt",         0, 3'd0, 8'h00, 3'd5, 8'h00);
      addVec("rst_base",        0, 3'd0, 8'h00, 3'd6, 8'h00);
      addVec("ptr_hi",          1, 3'd0, 8'h12, 3'd0, 8'h12);
      addVec("ptr_lo",          1, 3'd1, 8'h34, 3'd1, 8'h34);
      addVec("write_adv_lo",    1, 3'd2, 8'hA5, 3'd1, 8'h36);
      addVec("write_adv_hi",    0, 3'd0, 8'h00, 3'd0, 8'h12);
      addVec("move_back",       1, 3'd3, 8'h0E, 3'd1, 8'h34);
      addVec("read_pack",       0, 3'd0, 8'h00, 3'd2, 8'hA5);
      addVec("read_noside",     0, 3'd0, 8'h00, 3'd1, 8'h34);
      addVec("hi_10",           1, 3'd0, 8'h10, 3'd0, 8'h10);
      addVec("lo_ff",           1, 3'd1, 8'hFF, 3'd1, 8'hFF);
      addVec("move_lo_wrap",    1, 3'd3, 8'h11, 3'd1, 8'h00);
      addVec("move_no_carry",   0, 3'd0, 8'h00, 3'd0, 8'h11);
      addVec("hi_0",            1, 3'd0, 8'h00, 3'd0, 8'h00);
      addVec("lo_0",            1, 3'd1, 8'h00, 3'd1, 8'h00);
      addVec("move_neg_hi",     1, 3'd3, 8'hF1, 3'd0, 8'hFF);
      addVec("move_pos_lo",     0, 3'd0, 8'h00, 3'd1, 8'h01);
      addVec("color_trunc",     1, 3'd4, 8'h37, 3'd4, 8'h07);
      addVec("base_wr",         1, 3'd6, 8'h5A, 3'd6, 8'h5A);
      addVec("reserved",        1, 3'd7, 8'hFF, 3'd7, 8'h00);
      addVec("fill0_busy",      1, 3'd5, 8'h00, 3'd3, 8'h00);
      addVec("fill0_cnt",       0, 3'd0, 8'h00, 3'd5, 8'h00);
      addVec("hi_ff",           1, 3'd0, 8'hFF, 3'd0, 8'hFF);
      addVec("lo_ff2",          1, 3'd1, 8'hFF, 3'd1, 8'hFF);
      addVec("write_wrap_lo",   1, 3'd2, 8'h3C, 3'd1, 8'h01);
      addVec("write_wrap_hi",   0, 3'd0, 8'h00, 3'd0, 8'h00);
      addVec("lo_back",         1, 3'd1, 8'hFF, 3'd1, 8'hFF);
      addVec("read_wrap_pack",  1, 3'd0, 8'hFF, 3'd2, 8'h3C);

      repeat (2) @(negedge clk);
      reset = 1'b1;
      pushExp("rst_rgb", K_RGB, 8'h00);
      pushExp("rst_busy_port", K_BUSY, 8'h00);
      #1;
      checkOutput();
      checkOutput();

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Fill of 16 pixels with ignored pointer/write traffic and a mid-fill colour change.
      cpuWrite(3'd4, 8'h07);
      cpuWrite(3'd0, 8'h02);
      cpuWrite(3'd1, 8'h00);
      cpuWrite(3'd5, 8'd16);
      for (int cyc = 0; cyc < 16; cyc++) begin
         pushExp($sformatf("fill_busy_%0d", cyc), K_BUSY, 8'h01);
         reg_sel = 3'd5;
         pushExp($sformatf("fill_cnt_%0d", cyc), K_RD, 8'(16 - cyc));
         #1;
         checkOutput();
         checkOutput();
         reg_we = 1'b0;
         if (cyc == 2) begin
            reg_sel = 3'd2; reg_wdata = 8'hFF; reg_we = 1'b1;
         end else if (cyc == 3) begin
            reg_sel = 3'd1; reg_wdata = 8'h00; reg_we = 1'b1;
         end else if (cyc == 5) begin
            reg_sel = 3'd4; reg_wdata = 8'h03; reg_we = 1'b1;
         end
         @(negedge clk);
      end
      reg_we = 1'b0;
      pushExp("fill_done_busy", K_BUSY, 8'h00);
      #1;
      checkOutput();
      readCheck("fill_ptr_hi", 3'd0, 8'h02);
      readCheck("fill_ptr_lo", 3'd1, 8'h10);
      cpuWrite(3'd1, 8'h00);
      for (int i = 0; i < 8; i++) begin
         readCheck($sformatf("fill_pix_%0d", i), 3'd2, (i < 3) ? 8'h77 : 8'h33);
         cpuWrite(3'd3, 8'h02);
      end

      // Fill across the top of the address space.
      cpuWrite(3'd4, 8'h05);
      cpuWrite(3'd0, 8'hFF);
      cpuWrite(3'd1, 8'hFF);
      cpuWrite(3'd5, 8'd2);
      repeat (3) @(negedge clk);
      readCheck("wrapfill_busy", 3'd3, 8'h00);
      readCheck("wrapfill_hi", 3'd0, 8'h00);
      readCheck("wrapfill_lo", 3'd1, 8'h01);
      cpuWrite(3'd0, 8'hFF);
      cpuWrite(3'd1, 8'hFF);
      readCheck("wrapfill_pix", 3'd2, 8'h55);

      // Scan-out: base is latched during the blank line and only affects the next frame.
      cpuWrite(3'd0, 8'h20); cpuWrite(3'd1, 8'h00);
      cpuWrite(3'd2, 8'h12); cpuWrite(3'd2, 8'h34);
      cpuWrite(3'd0, 8'h30); cpuWrite(3'd1, 8'h00);
      cpuWrite(3'd2, 8'h9A); cpuWrite(3'd2, 8'hBC);
      cpuWrite(3'd6, 8'h30);
      scanCycle(9'd0, 9'd240, 8'h00, "f1_vblank");
      reg_sel = 3'd6; reg_wdata = 8'h20; reg_we = 1'b1;
      scanCycle(9'd0, 9'd0, 8'h09, "f1_px0");
      reg_we = 1'b0;
      scanCycle(9'd1, 9'd0, 8'h0A, "f1_px1");
      scanCycle(9'd2, 9'd0, 8'h0B, "f1_px2");
      scanCycle(9'd3, 9'd0, 8'h0C, "f1_px3");
      scanCycle(9'd300, 9'd0, 8'h00, "f1_hblank");
      readCheck("scan_base", 3'd6, 8'h20);
      scanCycle(9'd0, 9'd240, 8'h00, "f2_vblank");
      cpuWrite(3'd0, 8'h20);
      cpuWrite(3'd1, 8'h00);
      reg_sel = 3'd2; reg_wdata = 8'hEE; reg_we = 1'b1;
      scanCycle(9'd0, 9'd0, 8'h01, "f2_px0_old");
      reg_we = 1'b0;
      scanCycle(9'd1, 9'd0, 8'h0E, "f2_px1_new");
      scanCycle(9'd2, 9'd0, 8'h03, "f2_px2");
      scanCycle(9'd3, 9'd0, 8'h04, "f2_px3");
      scanCycle(9'd0, 9'd300, 8'h00, "f2_vblank_rgb");

      // Reset in the middle of a long fill.
      cpuWrite(3'd4, 8'h01);
      cpuWrite(3'd0, 8'h40);
      cpuWrite(3'd1, 8'h00);
      cpuWrite(3'd5, 8'd200);
      repeat (50) @(negedge clk);
      pushExp("midfill_busy", K_BUSY, 8'h01);
      #1;
      checkOutput();
      reset = 1'b0;
      hpos = 9'd0;
      vpos = 9'd0;
      @(negedge clk);
      reset = 1'b1;
      pushExp("rstfill_busy", K_BUSY, 8'h00);
      pushExp("rstfill_rgb", K_RGB, 8'h00);
      #1;
      checkOutput();
      checkOutput();
      pushExp("rstfill_scan0", K_RGB, 8'h05);
      @(negedge clk);
      checkOutput();
      vpos = 9'd300;
      readCheck("rstfill_hi", 3'd0, 8'h00);
      readCheck("rstfill_lo", 3'd1, 8'h00);
      readCheck("rstfill_cnt", 3'd5, 8'h00);
      readCheck("rstfill_color", 3'd4, 8'h00);
      readCheck("rstfill_busy_rd", 3'd3, 8'h00);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
